buzzer_melody_seq: RTL
======================

// Module: buzzer_melody_seq
// PURPOSE
// Initiator side of the buzzer tone interface (en_i / cmp_i of buzzer).
// Replaces a hard-wired tone compare value. On a start request it plays a fixed
// 8-note melody from an internal ROM, driving tone enable and tone compare value
// note by note, with a silent gap after each note. Reports busy/done to the
// controlling FSM. Sits between the exercise logic and the buzzer instance.
// PARAMETERS
// CMP_W      22         width of tone compare value (matches buzzer cmp_i)
// TICK_DIV   5_000_000  clk cycles per duration tick (100 ms @ 50 MHz clk_i)
// GAP_TICKS  1          silent ticks after every note; 0 = no gap
// PORTS
// clk_i       in   1      system clock, 50 MHz
// rst_n_i     in   1      asynchronous reset, active low
// start_i     in   1      start request, sampled high while idle
// abort_i     in   1      stop playback immediately
// tone_en_o   out  1      to buzzer en_i; 1 = tone sounding
// tone_cmp_o  out  CMP_W  to buzzer cmp_i; half-period compare value
// busy_o      out  1      1 while a melody is in progress
// done_o      out  1      1-cycle pulse when melody completes normally
// note_idx_o  out  3      index of current note, 0..7
// BEHAVIOUR
// - Reset (rst_n_i low, async): state IDLE; all outputs 0; counters cleared.
// - ROM, idx: cmp/dur_ticks: 0:125000/2 1:111111/2 2:99206/2 3:0/1 (rest)
//   4:93633/2 5:83333/2 6:74405/2 7:62500/4. cmp==0 = rest (tone_en_o 0).
// - FSM states: IDLE, PLAY, GAP, DONE. All outputs registered.
// - IDLE: start_i=1 at edge N -> PLAY from cycle N+1; idx=0; tick cnt=0.
// - PLAY: tone_cmp_o=ROM[idx].cmp; tone_en_o=(cmp!=0); busy_o=1.
//   Lasts exactly dur*TICK_DIV cycles; then GAP (or next step if GAP_TICKS=0).
// - GAP: tone_en_o=0; tone_cmp_o holds last value; busy_o=1.
//   Lasts GAP_TICKS*TICK_DIV cycles.
// - After GAP: idx<7 -> idx+1, PLAY; idx==7 -> DONE.
// - DONE: one cycle; done_o=1, busy_o=0, tone_en_o=0, tone_cmp_o=0; -> IDLE.
// - Tick counter counts 0..TICK_DIV-1; wraps at TICK_DIV-1. Counter width is
//   $clog2(TICK_DIV). Duration counter 4 bits; dur field 0 is treated as 1.
// - start_i while PLAY/GAP/DONE: ignored. No queueing, no restart.
// - abort_i=1 in any state: next cycle IDLE, all outputs 0, no done_o pulse.
//   abort_i has priority over start_i in the same cycle.
// - start_i held high continuously: melody restarts from the IDLE cycle that
//   follows DONE.
// - Async reset mid-note: outputs go to 0 immediately, without waiting for clk.
// - note_idx_o = idx during PLAY/GAP; 0 in IDLE/DONE.
// TESTING (TICK_DIV=4, GAP_TICKS=1)
// 1 reset -> all outputs 0; start at edge N -> tone_en_o=1, tone_cmp_o=125000,
//   busy_o=1 from N+1 to N+8; then tone_en_o=0 for 4 cycles.
// 2 full melody -> tone_cmp_o steps through ROM, note 3 with tone_en_o=0 for
//   4 cycles; done_o single pulse at N+101; busy_o high for exactly 100 cycles.
// 3 abort_i during note 4 -> next cycle all outputs 0, IDLE; no done_o pulse;
//   a new start_i restarts at idx 0.
// 4 start_i re-pulsed during PLAY and GAP -> no effect; done_o still at N+101.
// 5 rst_n_i low mid-note 6 -> outputs 0 asynchronously; after release stays IDLE.
// 6 GAP_TICKS=0 -> no silent cycles between notes; done_o at N+69.

Source files
------------

// File: rtl/buzzer_melody_seq.sv
// ============================================================================
// Module   : buzzer_melody_seq
// Purpose  : Plays a fixed 8-note melody on the buzzer tone interface. On a
//            start request it walks an internal ROM and drives the tone enable
//            and half-period compare value note by note. An optional silent
//            gap follows every note. It reports busy/done to the controlling
//            FSM.
// Ports    : clk_i       system clock
//            rst_n_i     asynchronous reset, active low
//            start_i     start request, accepted only while idle
//            abort_i     stop playback at the next edge, no done pulse
//            tone_en_o   buzzer enable (1 = tone sounding)
//            tone_cmp_o  buzzer half-period compare value
//            busy_o      melody in progress
//            done_o      1-cycle pulse on normal completion
//            note_idx_o  current note index during PLAY/GAP, else 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buzzer_melody_seq #(
    parameter int CMP_W     = 22,
    parameter int TICK_DIV  = 5_000_000,
    parameter int GAP_TICKS = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             tone_en_o,
    output logic [CMP_W-1:0] tone_cmp_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       note_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int         TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0] GAP_LAST = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

    // Melody ROM: compare value (0 = rest) and duration in ticks.
    function automatic logic [CMP_W-1:0] rom_cmp(input logic [2:0] i);
        case (i)
            3'd0:    rom_cmp = CMP_W'(125000);
            3'd1:    rom_cmp = CMP_W'(111111);
            3'd2:    rom_cmp = CMP_W'(99206);
            3'd3:    rom_cmp = CMP_W'(0);
            3'd4:    rom_cmp = CMP_W'(93633);
            3'd5:    rom_cmp = CMP_W'(83333);
            3'd6:    rom_cmp = CMP_W'(74405);
            default: rom_cmp = CMP_W'(62500);
        endcase
    endfunction

    function automatic logic [3:0] rom_dur(input logic [2:0] i);
        case (i)
            3'd3:    rom_dur = 4'd1;
            3'd7:    rom_dur = 4'd4;
            default: rom_dur = 4'd2;
        endcase
    endfunction

    state_t          state_q;
    logic [2:0]      idx_q;
    logic [TW-1:0]   tick_q;
    logic [3:0]      dur_q;
    logic            tone_en_q;
    logic [CMP_W-1:0] tone_cmp_q;
    logic            busy_q;
    logic            done_q;
    logic [2:0]      note_idx_q;

    logic [3:0]       dur_field;
    logic [3:0]       note_last;
    logic             tick_wrap;
    logic             note_end;
    logic             gap_end;
    logic             advance;
    logic [2:0]       idx_d;
    logic [CMP_W-1:0] cmp_d;

    assign dur_field = rom_dur(idx_q);
    // A zero duration field plays for one tick.
    assign note_last = (dur_field == 4'd0) ? 4'd0 : dur_field - 4'd1;
    assign tick_wrap = (tick_q == TICK_LAST);
    assign note_end  = (state_q == S_PLAY) && tick_wrap && (dur_q == note_last);
    assign gap_end   = (state_q == S_GAP)  && tick_wrap && (dur_q == GAP_LAST);
    // With no gap configured, the end of a note moves straight to the next step.
    assign advance   = gap_end || (note_end && (GAP_TICKS == 0));
    assign idx_d     = idx_q + 3'd1;
    assign cmp_d     = rom_cmp(idx_d);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tick_q     <= '0;
            dur_q      <= '0;
            tone_en_q  <= 1'b0;
            tone_cmp_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            note_idx_q <= '0;
        end else if (abort_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tick_q     <= '0;
            dur_q      <= '0;
            tone_en_q  <= 1'b0;
            tone_cmp_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            note_idx_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q    <= S_PLAY;
                        idx_q      <= '0;
                        tick_q     <= '0;
                        dur_q      <= '0;
                        tone_cmp_q <= rom_cmp(3'd0);
                        tone_en_q  <= (rom_cmp(3'd0) != '0);
                        busy_q     <= 1'b1;
                        note_idx_q <= '0;
                    end
                end
                S_PLAY, S_GAP: begin
                    if (tick_wrap) begin
                        tick_q <= '0;
                        if (advance) begin
                            dur_q <= '0;
                            if (idx_q == 3'd7) begin
                                state_q    <= S_DONE;
                                idx_q      <= '0;
                                tone_en_q  <= 1'b0;
                                tone_cmp_q <= '0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                note_idx_q <= '0;
                            end else begin
                                state_q    <= S_PLAY;
                                idx_q      <= idx_d;
                                tone_cmp_q <= cmp_d;
                                tone_en_q  <= (cmp_d != '0);
                                note_idx_q <= idx_d;
                            end
                        end else if (note_end) begin
                            // Silent gap keeps the last compare value on the bus.
                            state_q   <= S_GAP;
                            dur_q     <= '0;
                            tone_en_q <= 1'b0;
                        end else begin
                            dur_q <= dur_q + 4'd1;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tone_en_o  = tone_en_q;
    assign tone_cmp_o = tone_cmp_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign note_idx_o = note_idx_q;

endmodule

`default_nettype wire
